oclib_uart_arbiter: RTL and testbench

- Shares one UART byte channel (tx and rx) between NumClients requesters. Each requester has its own 8-bit data/valid/ready streams.
- Tx side: round-robin arbitration with a message-level lock. A client owns the UART until it sends EndByte or stops sending for IdleTimeout cycles.
- Rx side: bytes go to the most recent owner, so command/response traffic returns to the issuer.
- Sits between the UART and multiple command agents, e.g. a debug CSR engine and a console.

---
 rtl/oclib_uart_arbiter_if.sv | 40 ++++
 rtl/oclib_uart_arbiter.sv | 160 ++++++++++++++++
 tb/tb_oclib_uart_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oclib_uart_arbiter_if.sv
// Byte streams between the UART arbiter, its clients and the shared UART.
//
// Handshake: every stream is valid/ready. A byte moves on a cycle where
// valid and ready are both high. A source keeps data stable while valid is
// high and ready is low, and a source never makes valid depend on ready.
interface oclib_uart_arbiter_if #(
   parameter int NumClients = 2
);
   // client side, one byte lane per client at bits [8i+7:8i]
   logic [8*NumClients-1:0] clientTxData;
   logic [NumClients-1:0]   clientTxValid;
   logic [NumClients-1:0]   clientTxReady;
   logic [7:0]              clientRxData;
   logic [NumClients-1:0]   clientRxValid;
   logic [NumClients-1:0]   clientRxReady;

   // UART side
   logic [7:0]              uartTxData;
   logic                    uartTxValid;
   logic                    uartTxReady;
   logic [7:0]              uartRxData;
   logic                    uartRxValid;
   logic                    uartRxReady;

   // the arbiter
   modport master (
      input  clientTxData, clientTxValid, clientRxReady,
      input  uartTxReady, uartRxData, uartRxValid,
      output clientTxReady, clientRxData, clientRxValid,
      output uartTxData, uartTxValid, uartRxReady
   );

   // clients and UART seen together as the environment
   modport slave (
      output clientTxData, clientTxValid, clientRxReady,
      output uartTxReady, uartRxData, uartRxValid,
      input  clientTxReady, clientRxData, clientRxValid,
      input  uartTxData, uartTxValid, uartRxReady
   );
endinterface

// File: rtl/oclib_uart_arbiter.sv
// Shares one UART byte channel between NumClients requesters.
// Tx: round-robin grant, then the owner keeps the UART for a whole message,
// which ends on EndByte or after IdleTimeout cycles without an owner byte.
// Rx: bytes are steered, with no storage, to the current or most recent
// owner so a response returns to the client that issued the command.
// The FSM state is visible directly on the locked output (IDLE=0, LOCKED=1).
module oclib_uart_arbiter #(
   parameter int         NumClients   = 2,
   parameter logic [7:0] EndByte      = 8'h0A,
   parameter int         IdleTimeout  = 1024,
   parameter int         CounterWidth = (IdleTimeout > 0) ? $clog2(IdleTimeout + 1) : 1,
   localparam int        OwnerWidth   = $clog2(NumClients)
) (
   input  logic                    clock,
   input  logic                    reset,
   oclib_uart_arbiter_if.master    bus,
   output logic [OwnerWidth-1:0]   owner,
   output logic                    locked
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // idle counter value on whose no-transfer cycle the lock is dropped
   localparam logic [CounterWidth-1:0] TimeoutLast =
      CounterWidth'((IdleTimeout > 0) ? IdleTimeout - 1 : 0);
   localparam logic                    TimeoutOn   = (IdleTimeout > 0);
   localparam logic [OwnerWidth-1:0]   LastClient  = OwnerWidth'(NumClients - 1);

   state_t                  state_q, state_d;
   logic [OwnerWidth-1:0]   owner_q, owner_d;
   logic [OwnerWidth-1:0]   rr_q, rr_d;       // last winner; search starts after it
   logic [CounterWidth-1:0] idle_q, idle_d;

   logic [7:0]              tx_data_sel;
   logic                    tx_valid_sel;
   logic                    rx_ready_sel;
   logic                    tx_xfer;

   logic [OwnerWidth-1:0]   win_hi, win_lo, grant_idx;
   logic                    hit_hi, hit_lo, grant_hit;

   assign locked = (state_q == LOCKED);
   assign owner  = owner_q;

   // Owner lane select for the tx pass-through and the rx ready return.
   always_comb begin
      tx_data_sel  = 8'h00;
      tx_valid_sel = 1'b0;
      rx_ready_sel = 1'b0;
      for (int i = 0; i < NumClients; i++) begin
         if (OwnerWidth'(i) == owner_q) begin
            tx_data_sel  = bus.clientTxData[8*i +: 8];
            tx_valid_sel = bus.clientTxValid[i];
            rx_ready_sel = bus.clientRxReady[i];
         end
      end
   end

   // Stream outputs: tx passes through only while locked, rx always follows owner.
   always_comb begin
      bus.uartTxData    = tx_data_sel;
      bus.uartTxValid   = locked & tx_valid_sel;
      bus.uartRxReady   = rx_ready_sel;
      bus.clientRxData  = bus.uartRxData;
      bus.clientTxReady = '0;
      bus.clientRxValid = '0;
      for (int i = 0; i < NumClients; i++) begin
         if (OwnerWidth'(i) == owner_q) begin
            bus.clientTxReady[i] = locked & bus.uartTxReady;
            bus.clientRxValid[i] = bus.uartRxValid;
         end
      end
   end

   // Round-robin pick: lowest requester above the last winner, else lowest overall.
   always_comb begin
      win_hi = '0;
      win_lo = '0;
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      for (int i = NumClients - 1; i >= 0; i--) begin
         if (bus.clientTxValid[i]) begin
            win_lo = OwnerWidth'(i);
            hit_lo = 1'b1;
            if (i > int'(rr_q)) begin
               win_hi = OwnerWidth'(i);
               hit_hi = 1'b1;
            end
         end
      end
      grant_hit = hit_lo;
      grant_idx = hit_hi ? win_hi : win_lo;
   end

   assign tx_xfer = bus.uartTxValid & bus.uartTxReady;

   // Next state: grant in IDLE, hold the lock until EndByte or idle timeout.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      idle_d  = idle_q;
      case (state_q)
         IDLE: begin
            if (grant_hit) begin
               owner_d = grant_idx;
               rr_d    = grant_idx;
               idle_d  = '0;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (tx_xfer) begin
               idle_d = '0;
               if (tx_data_sel == EndByte) begin
                  state_d = IDLE;
               end
            end else begin
               // a stalled UART counts as idle: the owner moved no byte
               if (TimeoutOn && (idle_q == TimeoutLast)) begin
                  state_d = IDLE;
               end
               if (idle_q != '1) begin
                  idle_d = idle_q + CounterWidth'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset drops any lock at once and favours client 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= LastClient;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         idle_q  <= idle_d;
      end
   end

   // At most one client may see tx ready, and owner stays a real client.
   always @(posedge clock) begin
      if (!reset) begin
         assert ($onehot0(bus.clientTxReady));
         assert (int'(owner_q) < NumClients);
      end
   end

endmodule

// File: tb/tb_oclib_uart_arbiter.sv
// Bench for oclib_uart_arbiter: a 4-client, IdleTimeout=8 instance checked
// every cycle against a behavioural model and a tx byte scoreboard, plus a
// 2-client instance with the timeout disabled.
module tb_oclib_uart_arbiter;

   localparam int NC = 4;
   localparam int TO = 8;
   localparam logic [7:0] EB = 8'h0A;

   logic clk;
   logic rst;
   logic [1:0] owner;
   logic locked;

   logic rst2;
   logic owner2;
   logic locked2;

   oclib_uart_arbiter_if #(.NumClients(NC)) bus ();
   oclib_uart_arbiter_if #(.NumClients(2))  bus2 ();

   oclib_uart_arbiter #(.NumClients(NC), .EndByte(EB), .IdleTimeout(TO)) dut (
      .clock  (clk),
      .reset  (rst),
      .bus    (bus.master),
      .owner  (owner),
      .locked (locked)
   );

   oclib_uart_arbiter #(.NumClients(2), .EndByte(EB), .IdleTimeout(0)) dut2 (
      .clock  (clk),
      .reset  (rst2),
      .bus    (bus2.master),
      .owner  (owner2),
      .locked (locked2)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [11:0] exp_q[$];   // {owner(4), byte(8)} of each expected UART tx transfer

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_push(input int o, input logic [7:0] d);
      logic [3:0] o4;
      o4 = o[3:0];
      exp_q.push_back({o4, d});
   endtask

   // ---------------- drivers ----------------
   logic [7:0] src_q [NC][$];   // pending tx bytes per client
   logic [NC-1:0] fire_s;       // client tx handshakes seen in the last cycle
   logic       n_rst;
   logic       n_utr;
   logic       n_rxv;
   logic [7:0] n_rxd;
   logic [NC-1:0] n_rxr;

   task automatic drive();
      for (int i = 0; i < NC; i++) begin
         if (src_q[i].size() > 0) begin
            bus.clientTxValid[i]       = 1'b1;
            bus.clientTxData[8*i +: 8] = src_q[i][0];
         end else begin
            bus.clientTxValid[i]       = 1'b0;
            bus.clientTxData[8*i +: 8] = 8'h00;
         end
      end
   endtask

   // one cycle: inputs change just after posedge, bench looks at the negedge
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
         if (fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      rst             = n_rst;
      bus.uartTxReady = n_utr;
      bus.uartRxValid = n_rxv;
      bus.uartRxData  = n_rxd;
      bus.clientRxReady = n_rxr;
      drive();
      @(negedge clk);
      fire_s = bus.clientTxValid & bus.clientTxReady;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      n_rst = 1'b1;
      ticks(2);
      n_rst = 1'b0;
      tick();
   endtask

   // ---------------- behavioural model + compare ----------------
   // Model view: a client holds the UART from its grant until it has sent
   // EndByte or has moved nothing for TO consecutive locked cycles; the next
   // grant goes to the first requester after the previous winner.
   bit m_ok = 1'b0;
   bit m_locked;
   int m_owner;
   int m_last;
   int m_run;

   logic [NC-1:0] e_txr;
   logic [NC-1:0] e_rxv;
   logic          e_txv;
   logic          m_xfer;
   logic [7:0]    m_byte;
   logic [11:0]   sb_e;

   always @(negedge clk) begin
      if (m_ok) begin
         e_txv = m_locked && bus.clientTxValid[m_owner];
         e_txr = '0;
         if (m_locked) e_txr[m_owner] = bus.uartTxReady;
         e_rxv = '0;
         e_rxv[m_owner] = bus.uartRxValid;
         m_byte = bus.clientTxData[8*m_owner +: 8];
         chk("locked", locked, m_locked);
         chk("owner", owner, m_owner);
         chk("uart_tx_valid", bus.uartTxValid, e_txv);
         chk("client_tx_ready", bus.clientTxReady, e_txr);
         if (e_txv) chk("uart_tx_data", bus.uartTxData, m_byte);
         chk("client_rx_data", bus.clientRxData, bus.uartRxData);
         chk("client_rx_valid", bus.clientRxValid, e_rxv);
         chk("uart_rx_ready", bus.uartRxReady, bus.clientRxReady[m_owner]);

         if (bus.uartTxValid === 1'b1 && bus.uartTxReady === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_unexpected: got %h/%h expected no transfer", owner, bus.uartTxData);
            end else begin
               sb_e = exp_q.pop_front();
               chk("sb_tx", {2'b00, owner, bus.uartTxData}, sb_e);
            end
         end

         m_xfer = e_txv && bus.uartTxReady;
      end

      if (rst) begin
         m_ok     = 1'b1;
         m_locked = 1'b0;
         m_owner  = 0;
         m_last   = NC - 1;
         m_run    = 0;
      end else if (m_ok) begin
         if (!m_locked) begin
            for (int k = 1; k <= NC; k++) begin
               if (!m_locked && bus.clientTxValid[(m_last + k) % NC]) begin
                  m_owner  = (m_last + k) % NC;
                  m_last   = m_owner;
                  m_run    = 0;
                  m_locked = 1'b1;
               end
            end
         end else if (m_xfer) begin
            m_run = 0;
            if (m_byte == EB) m_locked = 1'b0;
         end else begin
            m_run++;
            if (TO != 0 && m_run == TO) m_locked = 1'b0;
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      n_rst = 1'b1;
      n_utr = 1'b0;
      n_rxv = 1'b0;
      n_rxd = 8'h00;
      n_rxr = '0;
      fire_s = '0;
      bus.clientTxData  = '0;
      bus.clientTxValid = '0;
      bus.clientRxReady = '0;
      bus.uartTxReady   = 1'b0;
      bus.uartRxData    = 8'h00;
      bus.uartRxValid   = 1'b0;
      rst2 = 1'b1;
      bus2.clientTxData  = '0;
      bus2.clientTxValid = '0;
      bus2.clientRxReady = '0;
      bus2.uartTxReady   = 1'b0;
      bus2.uartRxData    = 8'h00;
      bus2.uartRxValid   = 1'b0;

      // reset state
      do_reset();
      chk("rst_locked", locked, 0);
      chk("rst_owner", owner, 0);
      chk("rst_client_tx_ready", bus.clientTxReady, 0);
      chk("rst_uart_tx_valid", bus.uartTxValid, 0);
      chk("rst_client_rx_valid", bus.clientRxValid, 0);

      // single client message
      n_utr = 1'b1;
      src_q[1].push_back(8'h41);
      src_q[1].push_back(8'h42);
      src_q[1].push_back(8'h0A);
      exp_push(1, 8'h41);
      exp_push(1, 8'h42);
      exp_push(1, 8'h0A);
      tick();
      chk("single_grant_cycle_locked", locked, 0);
      chk("single_grant_cycle_ready", bus.clientTxReady, 0);
      tick();
      chk("single_locked", locked, 1);
      chk("single_owner", owner, 1);
      ticks(3);
      chk("single_release", locked, 0);
      chk("single_sb_empty", exp_q.size(), 0);

      // rx routing to the last owner
      n_rxv = 1'b1;
      n_rxd = 8'hA5;
      n_rxr = 4'b0000;
      tick();
      chk("rx_valid_onehot", bus.clientRxValid, 4'b0010);
      chk("rx_data", bus.clientRxData, 8'hA5);
      chk("rx_ready_held", bus.uartRxReady, 0);
      n_rxr = 4'b0010;
      tick();
      chk("rx_ready_owner", bus.uartRxReady, 1);
      n_rxr = 4'b0001;
      tick();
      chk("rx_ready_other", bus.uartRxReady, 0);
      n_rxv = 1'b0;
      n_rxr = '0;
      tick();

      // contention between clients 0 and 1 from reset
      do_reset();
      src_q[0].push_back(8'h10);
      src_q[0].push_back(8'h11);
      src_q[0].push_back(8'h0A);
      src_q[1].push_back(8'h20);
      src_q[1].push_back(8'h0A);
      exp_push(0, 8'h10);
      exp_push(0, 8'h11);
      exp_push(0, 8'h0A);
      exp_push(1, 8'h20);
      exp_push(1, 8'h0A);
      tick();
      tick();
      chk("cont_first_owner", owner, 0);
      ticks(3);
      chk("cont_gap_idle", locked, 0);
      tick();
      chk("cont_second_owner", owner, 1);
      chk("cont_second_locked", locked, 1);
      ticks(4);
      chk("cont_sb_empty", exp_q.size(), 0);

      // fairness with one-byte messages from every client
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NC; i++) begin
            src_q[i].push_back(EB);
            exp_push(i, EB);
         end
      end
      ticks(18);
      chk("fair_sb_empty", exp_q.size(), 0);

      // idle timeout with client 3 waiting
      src_q[2].push_back(8'h55);
      exp_push(2, 8'h55);
      exp_push(3, 8'h66);
      exp_push(3, 8'h0A);
      tick();
      src_q[3].push_back(8'h66);
      src_q[3].push_back(8'h0A);
      tick();
      chk("to_owner", owner, 2);
      chk("to_locked", locked, 1);
      ticks(8);
      chk("to_still_locked", locked, 1);
      tick();
      chk("to_released", locked, 0);
      tick();
      chk("to_next_owner", owner, 3);
      chk("to_next_locked", locked, 1);
      ticks(4);
      chk("to_sb_empty", exp_q.size(), 0);

      // backpressure counts as idle
      n_utr = 1'b0;
      src_q[0].push_back(8'h77);
      src_q[0].push_back(8'h0A);
      exp_push(0, 8'h77);
      exp_push(0, 8'h0A);
      tick();
      ticks(8);
      chk("bp_locked", locked, 1);
      chk("bp_no_ready", bus.clientTxReady, 0);
      tick();
      chk("bp_timeout", locked, 0);
      ticks(11);
      n_utr = 1'b1;
      ticks(12);
      chk("bp_sb_empty", exp_q.size(), 0);

      // reset in the middle of a message
      src_q[1].push_back(8'h31);
      src_q[1].push_back(8'h32);
      src_q[1].push_back(8'h33);
      src_q[1].push_back(8'h0A);
      exp_push(1, 8'h31);
      exp_push(1, 8'h32);
      exp_push(1, 8'h33);
      exp_push(1, 8'h0A);
      ticks(3);
      chk("mid_owner_before", owner, 1);
      n_rst = 1'b1;
      tick();
      n_rst = 1'b0;
      tick();
      chk("mid_owner_after", owner, 0);
      chk("mid_locked_after", locked, 0);
      ticks(4);
      chk("mid_sb_empty", exp_q.size(), 0);

      // timeout disabled: lock held through a long stall
      rst2 = 1'b0;
      bus2.clientTxValid = 2'b01;
      bus2.clientTxData  = {8'h00, 8'h99};
      bus2.uartTxReady   = 1'b0;
      tick();
      chk("nto_locked", locked2, 1);
      chk("nto_owner", owner2, 0);
      ticks(40);
      chk("nto_held", locked2, 1);
      chk("nto_tx_valid", bus2.uartTxValid, 1);
      chk("nto_no_ready", bus2.clientTxReady, 2'b00);
      bus2.clientTxData = {8'h00, 8'h0A};
      bus2.uartTxReady  = 1'b1;
      tick();
      chk("nto_release", locked2, 0);
      bus2.clientTxValid = 2'b00;
      tick();

      chk("final_sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
